// File: rtl/plab3_mem_domain_line_responder.sv
// Line-granular backing memory with a per-line owner-domain tag and fixed response latency.
// Optional PLAB3_MEM_RESPONDER_OOB_CHECK_EN: out-of-range addresses are suppressed and answered with type 7.
module plab3_mem_domain_line_responder #(
    parameter int p_nlines       = 64,
    parameter int p_latency      = 2,
    parameter int p_opaque_nbits = 8,
    parameter int abw            = 32,
    parameter int clw            = 128
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   domain,
    input  logic                                   memreq_val,
    output logic                                   memreq_rdy,
    input  logic [3+p_opaque_nbits+abw+4+clw-1:0]  memreq_msg,
    output logic                                   memresp_val,
    input  logic                                   memresp_rdy,
    output logic [3+p_opaque_nbits+4+clw-1:0]      memresp_msg
);
    localparam int IW    = $clog2(p_nlines);
    localparam int REQ_W = 3 + p_opaque_nbits + abw + 4 + clw;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t state, state_next;

    logic [2:0]                req_type;
    logic [p_opaque_nbits-1:0] req_opaque;
    logic [abw-1:0]            req_addr;
    logic [clw-1:0]            req_data;
    logic                      oob_req;

    assign req_type   = memreq_msg[REQ_W-1 -: 3];
    assign req_opaque = memreq_msg[REQ_W-4 -: p_opaque_nbits];
    assign req_addr   = memreq_msg[clw+4 +: abw];
    assign req_data   = memreq_msg[clw-1:0];

    logic unused_bits;
`ifdef PLAB3_MEM_RESPONDER_OOB_CHECK_EN
    assign oob_req     = |req_addr[abw-1:4+IW];
    assign unused_bits = ^{memreq_msg[clw +: 4], req_addr[3:0]};
`else
    assign oob_req     = 1'b0;
    assign unused_bits = ^{memreq_msg[clw +: 4], req_addr[3:0], req_addr[abw-1:4+IW]};
`endif

    logic [2:0]                r_type;
    logic [p_opaque_nbits-1:0] r_opaque;
    logic [IW-1:0]             r_idx;
    logic [clw-1:0]            r_data;
    logic                      r_dom;
    logic                      r_oob;
    logic [3:0]                cnt;

    logic [clw-1:0] lines [p_nlines];
    logic           tags  [p_nlines];

    logic [2:0]                resp_type;
    logic [p_opaque_nbits-1:0] resp_opaque;
    logic [clw-1:0]            resp_data;

    logic accept, access, is_write;

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next  = state;
        memreq_rdy  = 1'b0;
        memresp_val = 1'b0;
        accept      = 1'b0;
        access      = 1'b0;
        case (state)
            IDLE: begin
                memreq_rdy = reset;
                if (memreq_val && reset) begin
                    accept     = 1'b1;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    access     = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                memresp_val = reset;
                if (memresp_rdy) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // INIT is a write whose response echoes the INIT type; unknown codes read.
    assign is_write = (r_type == 3'd1) || (r_type == 3'd2);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_type      <= '0;
            r_opaque    <= '0;
            r_idx       <= '0;
            r_data      <= '0;
            r_dom       <= 1'b0;
            r_oob       <= 1'b0;
            cnt         <= '0;
            resp_type   <= '0;
            resp_opaque <= '0;
            resp_data   <= '0;
            for (int i = 0; i < p_nlines; i++) begin
                lines[i] <= '0;
                tags[i]  <= 1'b0;
            end
        end else begin
            if (accept) begin
                r_type   <= req_type;
                r_opaque <= req_opaque;
                r_idx    <= req_addr[4 +: IW];
                r_data   <= req_data;
                r_dom    <= domain;
                r_oob    <= oob_req;
                cnt      <= 4'(p_latency - 1);
            end else if (state == WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (access) begin
                if (is_write && !r_oob) begin
                    lines[r_idx] <= r_data;
                    tags[r_idx]  <= r_dom;
                end
                resp_type   <= r_oob ? 3'd7 : r_type;
                resp_opaque <= r_opaque;
                // Lines owned by the other domain read back as zero.
                resp_data   <= (!is_write && !r_oob && tags[r_idx] == r_dom) ? lines[r_idx] : '0;
            end
        end
    end

    assign memresp_msg = {resp_type, resp_opaque, 4'd0, resp_data};

endmodule

// File: tb/tb_plab3_mem_domain_line_responder.sv
// Randomized and directed bench for plab3_mem_domain_line_responder against a line/tag array model.
module tb_plab3_mem_domain_line_responder;
    logic         clk;
    logic         reset;
    logic         domain;
    logic         memreq_val;
    logic         memreq_rdy;
    logic [174:0] memreq_msg;
    logic         memresp_val;
    logic         memresp_rdy;
    logic [142:0] memresp_msg;

    int n_checks = 0;
    int n_fail   = 0;

    logic [127:0] m_line [64];
    logic         m_tag  [64];

    plab3_mem_domain_line_responder dut (
        .clk(clk), .reset(reset), .domain(domain),
        .memreq_val(memreq_val), .memreq_rdy(memreq_rdy), .memreq_msg(memreq_msg),
        .memresp_val(memresp_val), .memresp_rdy(memresp_rdy), .memresp_msg(memresp_msg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model_clear();
        for (int i = 0; i < 64; i++) begin
            m_line[i] = '0;
            m_tag[i]  = 1'b0;
        end
    endfunction

    // Expected response for one request; updates the model memory.
    function automatic logic [142:0] model(input logic [2:0] t, input logic [7:0] o,
                                           input logic [31:0] a, input logic [127:0] d,
                                           input logic dom);
        int           idx = int'(a[9:4]);
        logic         oob = 1'b0;
        logic [2:0]   rt;
        logic [127:0] rd = '0;
`ifdef PLAB3_MEM_RESPONDER_OOB_CHECK_EN
        oob = (a[31:10] != 22'd0);
`endif
        rt = oob ? 3'd7 : t;
        if (t == 3'd1 || t == 3'd2) begin
            if (!oob) begin
                m_line[idx] = d;
                m_tag[idx]  = dom;
            end
        end else if (!oob && m_tag[idx] == dom) begin
            rd = m_line[idx];
        end
        return {rt, o, 4'd0, rd};
    endfunction

    task automatic txn(input logic [2:0] t, input logic [7:0] o, input logic [31:0] a,
                       input logic [127:0] d, input logic dom, input int stall,
                       output logic [142:0] msg, output int lat, output logic stable,
                       output logic rdy_after);
        int w = 0;
        stable = 1'b1; lat = -1; msg = '0; rdy_after = 1'b0;
        while (!memreq_rdy && w < 50) begin
            @(posedge clk); #1; w++;
        end
        memreq_val = 1'b1;
        memreq_msg = {t, o, a, 4'($urandom), d};
        domain     = dom;
        @(posedge clk); #1;
        memreq_val = 1'b0;
        domain     = 1'($urandom);
        lat = 1;
        while (!memresp_val && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
        if (!memresp_val) begin
            lat = -1;
            return;
        end
        msg = memresp_msg;
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            if (!memresp_val || memresp_msg !== msg || memreq_rdy) stable = 1'b0;
        end
        memresp_rdy = 1'b1;
        @(posedge clk); #1;
        memresp_rdy = 1'b0;
        rdy_after = memreq_rdy;
    endtask

    task automatic test_reset();
        logic [142:0] msg, exp;
        int lat;
        logic st, ra;
        reset = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_checks++;
        if (memreq_rdy !== 1'b0 || memresp_val !== 1'b0 || memresp_msg !== 143'd0) begin
            n_fail++;
            $display("FAIL reset_outputs rdy=%b val=%b msg=%h want 0 0 0", memreq_rdy, memresp_val, memresp_msg);
        end
        reset = 1'b1;
        model_clear();
        @(posedge clk); #1;
        n_checks++;
        if (memreq_rdy !== 1'b1 || memresp_val !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release rdy=%b val=%b want 1 0", memreq_rdy, memresp_val);
        end
        exp = model(3'd0, 8'h11, 32'h40, '0, 1'b0);
        txn(3'd0, 8'h11, 32'h40, '0, 1'b0, 0, msg, lat, st, ra);
        n_checks++;
        if (msg !== exp || exp !== {3'd0, 8'h11, 4'd0, 128'd0}) begin
            n_fail++;
            $display("FAIL reset_first_read got=%h want=%h", msg, exp);
        end
    endtask

    task automatic test_write_read();
        logic [142:0] msg;
        int lat;
        logic st, ra;
        logic [127:0] d = 128'hDEADBEEF_00112233_44556677_8899AABB;
        void'(model(3'd1, 8'h5A, 32'h100, d, 1'b1));
        txn(3'd1, 8'h5A, 32'h100, d, 1'b1, 0, msg, lat, st, ra);
        n_checks++;
        if (msg !== {3'd1, 8'h5A, 4'd0, 128'd0}) begin
            n_fail++;
            $display("FAIL write_resp got=%h want=%h", msg, {3'd1, 8'h5A, 4'd0, 128'd0});
        end
        n_checks++;
        if (lat !== 3) begin
            n_fail++;
            $display("FAIL write_latency got=%0d want=3", lat);
        end
        void'(model(3'd0, 8'h5B, 32'h100, '0, 1'b1));
        txn(3'd0, 8'h5B, 32'h100, '0, 1'b1, 0, msg, lat, st, ra);
        n_checks++;
        if (msg !== {3'd0, 8'h5B, 4'd0, d}) begin
            n_fail++;
            $display("FAIL read_same_domain got=%h want=%h", msg, {3'd0, 8'h5B, 4'd0, d});
        end
        n_checks++;
        if (lat !== 3) begin
            n_fail++;
            $display("FAIL read_latency got=%0d want=3", lat);
        end
    endtask

    task automatic test_cross_domain();
        logic [142:0] msg;
        int lat;
        logic st, ra;
        void'(model(3'd0, 8'h01, 32'h100, '0, 1'b0));
        txn(3'd0, 8'h01, 32'h100, '0, 1'b0, 0, msg, lat, st, ra);
        n_checks++;
        if (msg[127:0] !== 128'd0) begin
            n_fail++;
            $display("FAIL xdom_read_d0 got=%h want=0", msg[127:0]);
        end
        void'(model(3'd1, 8'h02, 32'h100, 128'h1, 1'b0));
        txn(3'd1, 8'h02, 32'h100, 128'h1, 1'b0, 0, msg, lat, st, ra);
        void'(model(3'd0, 8'h03, 32'h100, '0, 1'b1));
        txn(3'd0, 8'h03, 32'h100, '0, 1'b1, 0, msg, lat, st, ra);
        n_checks++;
        if (msg[127:0] !== 128'd0) begin
            n_fail++;
            $display("FAIL xdom_read_d1 got=%h want=0", msg[127:0]);
        end
        void'(model(3'd0, 8'h04, 32'h100, '0, 1'b0));
        txn(3'd0, 8'h04, 32'h100, '0, 1'b0, 0, msg, lat, st, ra);
        n_checks++;
        if (msg !== {3'd0, 8'h04, 4'd0, 128'h1}) begin
            n_fail++;
            $display("FAIL xdom_owner_read got=%h want=%h", msg, {3'd0, 8'h04, 4'd0, 128'h1});
        end
    endtask

    task automatic test_backpressure();
        logic [142:0] msg, exp;
        int lat;
        logic st, ra;
        exp = model(3'd0, 8'hB0, 32'h100, '0, 1'b0);
        txn(3'd0, 8'hB0, 32'h100, '0, 1'b0, 5, msg, lat, st, ra);
        n_checks++;
        if (st !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_stable got=%b want=1", st);
        end
        n_checks++;
        if (msg !== exp) begin
            n_fail++;
            $display("FAIL bp_msg got=%h want=%h", msg, exp);
        end
        n_checks++;
        if (ra !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_rdy_after got=%b want=1", ra);
        end
    endtask

    task automatic test_reset_mid_op();
        logic [142:0] msg;
        int lat;
        logic st, ra;
        logic seen = 1'b0;
        memreq_val = 1'b1;
        memreq_msg = {3'd1, 8'hC0, 32'h200, 4'd0, 128'hF};
        domain     = 1'b0;
        @(posedge clk); #1;
        memreq_val = 1'b0;
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        model_clear();
        for (int i = 0; i < 5; i++) begin
            if (memresp_val) seen = 1'b1;
            @(posedge clk); #1;
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_no_resp got=%b want=0", seen);
        end
        void'(model(3'd0, 8'hC1, 32'h200, '0, 1'b0));
        txn(3'd0, 8'hC1, 32'h200, '0, 1'b0, 0, msg, lat, st, ra);
        n_checks++;
        if (msg !== {3'd0, 8'hC1, 4'd0, 128'd0}) begin
            n_fail++;
            $display("FAIL midreset_read got=%h want=%h", msg, {3'd0, 8'hC1, 4'd0, 128'd0});
        end
    endtask

    task automatic test_wrap();
        logic [142:0] msg;
        int lat;
        logic st, ra;
        void'(model(3'd1, 8'hD0, 32'h400, 128'hA, 1'b0));
        txn(3'd1, 8'hD0, 32'h400, 128'hA, 1'b0, 0, msg, lat, st, ra);
        n_checks++;
`ifdef PLAB3_MEM_RESPONDER_OOB_CHECK_EN
        if (msg !== {3'd7, 8'hD0, 4'd0, 128'd0}) begin
`else
        if (msg !== {3'd1, 8'hD0, 4'd0, 128'd0}) begin
`endif
            n_fail++;
            $display("FAIL wrap_write_resp got=%h", msg);
        end
        void'(model(3'd0, 8'hD1, 32'h0, '0, 1'b0));
        txn(3'd0, 8'hD1, 32'h0, '0, 1'b0, 0, msg, lat, st, ra);
        n_checks++;
`ifdef PLAB3_MEM_RESPONDER_OOB_CHECK_EN
        if (msg !== {3'd0, 8'hD1, 4'd0, 128'd0}) begin
`else
        if (msg !== {3'd0, 8'hD1, 4'd0, 128'hA}) begin
`endif
            n_fail++;
            $display("FAIL wrap_read0 got=%h", msg);
        end
`ifdef PLAB3_MEM_RESPONDER_OOB_CHECK_EN
        void'(model(3'd0, 8'hD2, 32'h400, '0, 1'b0));
        txn(3'd0, 8'hD2, 32'h400, '0, 1'b0, 0, msg, lat, st, ra);
        n_checks++;
        if (msg !== {3'd7, 8'hD2, 4'd0, 128'd0}) begin
            n_fail++;
            $display("FAIL oob_read got=%h want=%h", msg, {3'd7, 8'hD2, 4'd0, 128'd0});
        end
`endif
    endtask

    task automatic test_random();
        logic [142:0] msg, exp;
        int lat;
        logic st, ra;
        logic [2:0] t;
        logic [31:0] a;
        logic [127:0] d;
        logic dom;
        logic [7:0] o;
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: t = 3'd1;
                4:          t = 3'd2;
                5:          t = 3'($urandom_range(3, 7));
                default:    t = 3'd0;
            endcase
            a = $urandom;
            a[9:4] = 6'($urandom_range(0, 7));
            if ($urandom_range(0, 3) != 0) a[31:10] = '0;
            d   = {$urandom, $urandom, $urandom, $urandom};
            dom = 1'($urandom);
            o   = 8'($urandom);
            exp = model(t, o, a, d, dom);
            txn(t, o, a, d, dom, $urandom_range(0, 2), msg, lat, st, ra);
            n_checks++;
            if (msg !== exp || lat !== 3 || st !== 1'b1) begin
                n_fail++;
                $display("FAIL rand_%0d got=%h lat=%0d st=%b want=%h lat=3 st=1", n, msg, lat, st, exp);
            end
        end
    endtask

    initial begin
        reset       = 1'b0;
        domain      = 1'b0;
        memreq_val  = 1'b0;
        memreq_msg  = '0;
        memresp_rdy = 1'b0;
        test_reset();
        test_write_read();
        test_cross_domain();
        test_backpressure();
        test_reset_mid_op();
        test_wrap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
